fetch_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of Decode. It holds the PC and a word-addressed instruction memory.
- It presents a registered Instruction/PC pair to Decode every cycle.
- It computes the next PC from PC+4, branch, jump and jump-register redirects, which are driven back from decode/execute control.
- It adds boot, stall, halt and address-fault handling.

---
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage holding the PC and a word-addressed imem,
// presenting a registered Instruction/PC pair to Decode.
module fetch_unit #(
   parameter int          IMEM_DEPTH = 256,
   parameter int          ADDR_BITS  = 8,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic                 Stall,
   input  logic                 Branch_Taken,
   input  logic [15:0]          Branch_Offset,
   input  logic                 Jump,
   input  logic [25:0]          Jump_Target,
   input  logic                 JumpReg,
   input  logic [31:0]          JumpReg_Addr,
   input  logic                 Imem_WrEn,
   input  logic [ADDR_BITS-1:0] Imem_WrAddr,
   input  logic [31:0]          Imem_WrData,
   output logic [31:0]          Instruction,
   output logic [31:0]          PC,
   output logic [31:0]          PC_Plus4,
   output logic                 Instr_Valid,
   output logic                 Halted,
   output logic                 Addr_Fault
);

   localparam logic [1:0] S_BOOT = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;

   logic [1:0]           r_state;
   logic [31:0]          r_pc;
   logic [31:0]          r_instr;
   logic                 r_valid;
   logic                 r_halted;
   logic                 r_fault;
   logic [31:0]          r_imem [IMEM_DEPTH];

   logic [31:0]          w_pc_plus4;
   logic [31:0]          w_br_off;
   logic [31:0]          w_npc;
   logic                 w_npc_bad;
   logic                 w_halt_op;
   logic                 w_wr_ok;
   logic [ADDR_BITS-1:0] w_rd_idx;
   logic [31:0]          w_rd_data;

   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_br_off   = {{14{Branch_Offset[15]}}, Branch_Offset, 2'b00};

   always_comb begin
      w_npc = w_pc_plus4;
      if (JumpReg)
         w_npc = JumpReg_Addr;
      else if (Jump)
         w_npc = {w_pc_plus4[31:28], Jump_Target, 2'b00};
      else if (Branch_Taken)
         w_npc = w_pc_plus4 + w_br_off;
   end

   assign w_npc_bad = (w_npc[1:0] != 2'b00) ||
                      ({2'b00, w_npc[31:2]} >= 32'(IMEM_DEPTH));
   assign w_halt_op = (r_instr[31:26] == 6'b111111);

   // BOOT fetches at the current PC; RUN fetches at the next PC
   assign w_rd_idx  = (r_state == S_BOOT) ? r_pc[ADDR_BITS+1:2]
                                          : w_npc[ADDR_BITS+1:2];
   assign w_rd_data = r_imem[w_rd_idx];

   if (IMEM_DEPTH < (1 << ADDR_BITS)) begin : g_wr_chk
      assign w_wr_ok = ({1'b0, Imem_WrAddr} < (ADDR_BITS+1)'(IMEM_DEPTH));
   end else begin : g_wr_all
      assign w_wr_ok = 1'b1;
   end

   // Load port is independent of reset so imem survives and can be filled in reset
   always_ff @(posedge Clk) begin
      if (Imem_WrEn && w_wr_ok)
         r_imem[Imem_WrAddr] <= Imem_WrData;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state  <= S_BOOT;
         r_pc     <= RESET_PC;
         r_instr  <= 32'h0;
         r_valid  <= 1'b0;
         r_halted <= 1'b0;
         r_fault  <= 1'b0;
      end else begin
         case (r_state)
            S_BOOT: begin
               r_instr <= w_rd_data;
               r_valid <= 1'b1;
               r_state <= S_RUN;
            end
            S_RUN: begin
               if (!Stall) begin
                  if (w_halt_op) begin
                     r_state  <= S_HALT;
                     r_halted <= 1'b1;
                     r_valid  <= 1'b0;
                     r_instr  <= 32'h0;
                  end else if (w_npc_bad) begin
                     r_state  <= S_HALT;
                     r_halted <= 1'b1;
                     r_fault  <= 1'b1;
                     r_valid  <= 1'b0;
                     r_instr  <= 32'h0;
                  end else begin
                     r_pc    <= w_npc;
                     r_instr <= w_rd_data;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign Instruction = r_instr;
   assign PC          = r_pc;
   assign PC_Plus4    = w_pc_plus4;
   assign Instr_Valid = r_valid;
   assign Halted      = r_halted;
   assign Addr_Fault  = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors for fetch_unit with
// hand-computed expected Instruction/PC/status values.
module tb_fetch_unit;

   logic        Clk;
   logic        Rst_n;
   logic        Stall;
   logic        Branch_Taken;
   logic [15:0] Branch_Offset;
   logic        Jump;
   logic [25:0] Jump_Target;
   logic        JumpReg;
   logic [31:0] JumpReg_Addr;
   logic        Imem_WrEn;
   logic [7:0]  Imem_WrAddr;
   logic [31:0] Imem_WrData;
   logic [31:0] Instruction;
   logic [31:0] PC;
   logic [31:0] PC_Plus4;
   logic        Instr_Valid;
   logic        Halted;
   logic        Addr_Fault;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [31:0] W_ADD  = 32'h0022_1820;
   localparam logic [31:0] W_SUB  = 32'h0022_1822;
   localparam logic [31:0] W_OR   = 32'h0022_1825;
   localparam logic [31:0] W_AND  = 32'h0022_1824;
   localparam logic [31:0] W_8    = 32'h1234_5678;
   localparam logic [31:0] W_16   = 32'hCAFE_0016;
   localparam logic [31:0] W_NEW1 = 32'h0BAD_0001;
   localparam logic [31:0] W_HALT = 32'hFC00_0000;

   fetch_unit dut (
      .Clk          (Clk),
      .Rst_n        (Rst_n),
      .Stall        (Stall),
      .Branch_Taken (Branch_Taken),
      .Branch_Offset(Branch_Offset),
      .Jump         (Jump),
      .Jump_Target  (Jump_Target),
      .JumpReg      (JumpReg),
      .JumpReg_Addr (JumpReg_Addr),
      .Imem_WrEn    (Imem_WrEn),
      .Imem_WrAddr  (Imem_WrAddr),
      .Imem_WrData  (Imem_WrData),
      .Instruction  (Instruction),
      .PC           (PC),
      .PC_Plus4     (PC_Plus4),
      .Instr_Valid  (Instr_Valid),
      .Halted       (Halted),
      .Addr_Fault   (Addr_Fault)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      Imem_WrEn   = 1'b1;
      Imem_WrAddr = a;
      Imem_WrData = d;
      tick();
      Imem_WrEn   = 1'b0;
   endtask

   task automatic clr_redir;
      Branch_Taken  = 1'b0;
      Branch_Offset = 16'h0;
      Jump          = 1'b0;
      Jump_Target   = 26'h0;
      JumpReg       = 1'b0;
      JumpReg_Addr  = 32'h0;
   endtask

   initial begin
      Rst_n       = 1'b0;
      Stall       = 1'b0;
      Imem_WrEn   = 1'b0;
      Imem_WrAddr = 8'h0;
      Imem_WrData = 32'h0;
      clr_redir();
      #2;
      wr(8'd0, W_ADD);
      wr(8'd1, W_SUB);
      wr(8'd2, W_OR);
      wr(8'd3, W_AND);
      wr(8'd8, W_8);
      wr(8'd16, W_16);

      chk("rst_pc", PC, 32'h0);
      chk("rst_pc4", PC_Plus4, 32'h4);
      chk("rst_instr", Instruction, 32'h0);
      chk("rst_valid", 32'(Instr_Valid), 32'h0);
      chk("rst_halt", 32'(Halted), 32'h0);
      chk("rst_fault", 32'(Addr_Fault), 32'h0);

      Rst_n = 1'b1;
      #1;
      chk("boot_valid", 32'(Instr_Valid), 32'h0);
      chk("boot_pc", PC, 32'h0);
      tick();
      chk("f0_instr", Instruction, W_ADD);
      chk("f0_pc", PC, 32'h0);
      chk("f0_valid", 32'(Instr_Valid), 32'h1);
      tick();
      chk("f1_instr", Instruction, W_SUB);
      chk("f1_pc", PC, 32'h4);
      tick();
      chk("f2_instr", Instruction, W_OR);
      chk("f2_pc", PC, 32'h8);

      Branch_Taken  = 1'b1;
      Branch_Offset = 16'hFFFE;
      tick();
      chk("br_pc", PC, 32'h4);
      chk("br_instr", Instruction, W_SUB);

      Jump        = 1'b1;
      Jump_Target = 26'h10;
      tick();
      chk("jmp_pc", PC, 32'h40);
      chk("jmp_instr", Instruction, W_16);

      clr_redir();
      Jump        = 1'b1;
      Jump_Target = 26'h1;
      tick();
      chk("jmp4_pc", PC, 32'h4);

      JumpReg      = 1'b1;
      JumpReg_Addr = 32'h20;
      Jump_Target  = 26'h10;
      tick();
      chk("jr_pc", PC, 32'h20);
      chk("jr_instr", Instruction, W_8);

      Stall         = 1'b1;
      JumpReg_Addr  = 32'h0;
      Branch_Taken  = 1'b1;
      Branch_Offset = 16'h0004;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_pc", PC, 32'h20);
         chk("stall_instr", Instruction, W_8);
         chk("stall_valid", 32'(Instr_Valid), 32'h1);
      end

      Stall = 1'b0;
      clr_redir();
      JumpReg      = 1'b1;
      JumpReg_Addr = 32'h22;
      tick();
      chk("mis_fault", 32'(Addr_Fault), 32'h1);
      chk("mis_halt", 32'(Halted), 32'h1);
      chk("mis_instr", Instruction, 32'h0);
      chk("mis_pc", PC, 32'h20);
      chk("mis_valid", 32'(Instr_Valid), 32'h0);
      JumpReg_Addr = 32'h0;
      tick();
      chk("hold_pc", PC, 32'h20);
      chk("hold_halt", 32'(Halted), 32'h1);

      Jump        = 1'b1;
      Jump_Target = 26'h10;
      #2;
      Rst_n = 1'b0;
      #1;
      chk("arst_pc", PC, 32'h0);
      chk("arst_fault", 32'(Addr_Fault), 32'h0);
      chk("arst_halt", 32'(Halted), 32'h0);
      chk("arst_valid", 32'(Instr_Valid), 32'h0);
      clr_redir();
      tick();
      Rst_n = 1'b1;
      Stall = 1'b1;
      tick();
      chk("bstall_valid", 32'(Instr_Valid), 32'h1);
      chk("bstall_instr", Instruction, W_ADD);
      chk("bstall_pc", PC, 32'h0);
      Stall        = 1'b0;
      JumpReg      = 1'b1;
      JumpReg_Addr = 32'h400;
      tick();
      chk("oor_fault", 32'(Addr_Fault), 32'h1);
      chk("oor_pc", PC, 32'h0);
      clr_redir();

      Rst_n = 1'b0;
      wr(8'd2, W_HALT);
      Rst_n = 1'b1;
      tick();
      chk("b3_instr", Instruction, W_ADD);
      Imem_WrEn   = 1'b1;
      Imem_WrAddr = 8'd1;
      Imem_WrData = W_NEW1;
      tick();
      Imem_WrEn = 1'b0;
      chk("rbw_instr", Instruction, W_SUB);
      chk("rbw_pc", PC, 32'h4);
      Jump        = 1'b1;
      Jump_Target = 26'h0;
      tick();
      chk("back_pc", PC, 32'h0);
      clr_redir();
      tick();
      chk("new1_instr", Instruction, W_NEW1);
      tick();
      chk("hop_pc", PC, 32'h8);
      chk("hop_instr", Instruction, W_HALT);
      chk("hop_pre", 32'(Halted), 32'h0);
      tick();
      chk("hlt_halt", 32'(Halted), 32'h1);
      chk("hlt_valid", 32'(Instr_Valid), 32'h0);
      chk("hlt_instr", Instruction, 32'h0);
      chk("hlt_pc", PC, 32'h8);
      chk("hlt_fault", 32'(Addr_Fault), 32'h0);
      tick();
      tick();
      chk("hlt_pc_late", PC, 32'h8);
      chk("hlt_pc4", PC_Plus4, 32'hC);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
